// File: rtl/encoder_dec_bcd.sv
// ---------------------------------------------------------------------------
// encoder_dec_bcd
// Keypad front end for the microwave oven controller. The ten decimal key
// lines are synchronised, reduced to one key code (the highest pressed key
// wins), and debounced. A tracker accepts each press once: it loads the BCD
// code and pulses an active-low strobe for one cycle. A new strobe needs a
// full, debounced release first.
//
// Parameters
//   SYNC_STAGES      flip-flop stages on decimal (min 2)
//   DEBOUNCE_CYCLES  identical consecutive samples needed to accept (min 1)
//
// Ports
//   clk      in   1   system clock, rising edge
//   reset    in   1   synchronous, active-high reset
//   decimal  in  10   key lines, active-high, bit i = key i, asynchronous
//   enable   in   1   active-low enable: 0 = accept keys, 1 = keypad locked
//   bcd      out  4   BCD code of the last accepted key, registered
//   loadn    out  1   active-low load strobe, one cycle per accepted press
// ---------------------------------------------------------------------------
module encoder_dec_bcd #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] decimal,
    input  logic       enable,
    output logic [3:0] bcd,
    output logic       loadn
);

    localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [3:0]       CODE_NONE = 4'hF;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

    // The highest pressed key wins. A bit that is X/Z fails the == 1'b1 test,
    // so it reads as "not pressed".
    function automatic logic [3:0] prio_code(input logic [9:0] v);
        logic [3:0] c;
        c = CODE_NONE;
        for (int i = 0; i < 10; i++) begin
            if (v[i] == 1'b1) begin
                c = 4'(i);
            end
        end
        return c;
    endfunction

    logic [9:0]       r_sync [SYNC_STAGES];
    logic [3:0]       r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [0:0]       r_state;
    logic [3:0]       r_bcd;
    logic             r_loadn;

    logic [3:0]       w_code;
    logic             w_stable;

    // Synchroniser stage: decimal is asynchronous to clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= decimal;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_code = prio_code(r_sync[SYNC_STAGES-1]);

    // Debounce stage. r_cnt is the run length of r_prev; it saturates at
    // DEBOUNCE_CYCLES. The run length of NONE is tracked the same way, so a
    // release is debounced as well.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= CODE_NONE;
            r_cnt  <= '0;
        end else begin
            r_prev <= w_code;
            if (w_code != r_prev) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_stable = (r_cnt == CNT_MAX);

    // Tracker stage. enable is used without synchronisation. This lets a key
    // that is already stable be accepted on the cycle after enable drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_bcd   <= 4'd0;
            r_loadn <= 1'b1;
        end else begin
            r_loadn <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_stable && (r_prev != CODE_NONE) && !enable) begin
                        r_bcd   <= r_prev;
                        r_loadn <= 1'b0;
                        r_state <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (w_stable && (r_prev == CODE_NONE)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bcd   = r_bcd;
    assign loadn = r_loadn;

endmodule

// File: tb/tb_encoder_dec_bcd.sv
module tb_encoder_dec_bcd;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int NONE            = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] decimal;
    logic       enable;
    logic [3:0] bcd;
    logic       loadn;

    int n_cmp = 0;
    int n_err = 0;

    encoder_dec_bcd #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .decimal(decimal),
        .enable (enable),
        .bcd    (bcd),
        .loadn  (loadn)
    );

    always #5 clk = ~clk;

    // Reference model. The key vectors seen by the debouncer are a delay line
    // of the raw inputs. The debouncer is modelled as a history of codes, and
    // a code counts as stable once its trailing run is DEBOUNCE_CYCLES long.
    logic [9:0] m_pipe[$];
    int         m_hist[$];
    bit         m_held;
    int         m_bcd;
    int         m_loadn;

    int strobes;
    int first_at;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int key_code(input logic [9:0] v);
        if (v == 10'd0) return NONE;
        return $clog2(int'(v) + 1) - 1;
    endfunction

    function automatic int run_len();
        int n = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] != m_hist[m_hist.size() - 1]) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_pipe.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back(10'd0);
            m_hist.delete();
            m_held  = 1'b0;
            m_bcd   = 0;
            m_loadn = 1;
        end else begin
            bit stable;
            int cur;
            stable  = (run_len() >= DEBOUNCE_CYCLES);
            cur     = (m_hist.size() > 0) ? m_hist[m_hist.size() - 1] : NONE;
            m_loadn = 1;
            if (!m_held && stable && cur != NONE && enable == 1'b0) begin
                m_bcd   = cur;
                m_loadn = 0;
                m_held  = 1'b1;
            end else if (m_held && stable && cur == NONE) begin
                m_held = 1'b0;
            end
            m_hist.push_back(key_code(m_pipe[m_pipe.size() - 1]));
            if (m_hist.size() > 32) void'(m_hist.pop_front());
            m_pipe.push_front(decimal);
            void'(m_pipe.pop_back());
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("bcd", int'(bcd), m_bcd);
        chk("loadn", int'(loadn), m_loadn);
    endtask

    task automatic run(input int n);
        strobes  = 0;
        first_at = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (loadn == 1'b0) begin
                strobes++;
                if (first_at == 0) first_at = i;
            end
        end
    endtask

    task automatic release_keys();
        decimal = 10'd0;
        run(8);
        chk("release_no_strobe", strobes, 0);
    endtask

    initial begin
        reset   = 1'b1;
        decimal = 10'd0;
        enable  = 1'b0;

        // Reset state.
        run(2);
        chk("reset_bcd", int'(bcd), 0);
        chk("reset_loadn", int'(loadn), 1);
        reset = 1'b0;

        // Single key, latency SYNC_STAGES + DEBOUNCE_CYCLES + 1.
        decimal = 10'd4;
        run(10);
        chk("t1_strobes", strobes, 1);
        chk("t1_latency", first_at, SYNC_STAGES + DEBOUNCE_CYCLES + 1);
        chk("t1_bcd", int'(bcd), 2);
        release_keys();

        // Priority between simultaneous keys.
        decimal = 10'd3;
        run(10);
        chk("t2a_strobes", strobes, 1);
        chk("t2a_bcd", int'(bcd), 1);
        release_keys();
        decimal = 10'd6;
        run(10);
        chk("t2b_strobes", strobes, 1);
        chk("t2b_bcd", int'(bcd), 2);
        release_keys();

        // Bounce on key 5: latency is counted from the last toggle.
        decimal = 10'd32; run(1);
        decimal = 10'd0;  run(1);
        decimal = 10'd32;
        run(10);
        chk("t3_strobes", strobes, 1);
        chk("t3_latency", first_at, SYNC_STAGES + DEBOUNCE_CYCLES + 1);
        chk("t3_bcd", int'(bcd), 5);
        release_keys();

        // Locked keypad, then unlock with key 9 stably held.
        enable  = 1'b1;
        decimal = 10'd512;
        run(10);
        chk("t4_locked_strobes", strobes, 0);
        chk("t4_locked_bcd", int'(bcd), 5);
        enable = 1'b0;
        run(3);
        chk("t4_strobes", strobes, 1);
        chk("t4_latency", first_at, 1);
        chk("t4_bcd", int'(bcd), 9);
        release_keys();

        // A second key while held does not re-strobe.
        decimal = 10'd8;
        run(10);
        chk("t5a_bcd", int'(bcd), 3);
        decimal = 10'd8 | 10'd128;
        run(10);
        chk("t5b_strobes", strobes, 0);
        chk("t5b_bcd", int'(bcd), 3);
        release_keys();
        decimal = 10'd128;
        run(10);
        chk("t5c_strobes", strobes, 1);
        chk("t5c_bcd", int'(bcd), 7);
        release_keys();

        // Reset during the debounce of key 8.
        decimal = 10'd256;
        run(3);
        chk("t6_pre_strobes", strobes, 0);
        reset = 1'b1;
        run(1);
        chk("t6_rst_loadn", int'(loadn), 1);
        reset = 1'b0;
        run(10);
        chk("t6_strobes", strobes, 1);
        chk("t6_latency", first_at, SYNC_STAGES + DEBOUNCE_CYCLES + 1);
        chk("t6_bcd", int'(bcd), 8);

        // Randomised segments checked cycle by cycle against the model.
        for (int seg = 0; seg < 120; seg++) begin
            int len;
            case ($urandom_range(0, 3))
                0:       decimal = 10'd0;
                1:       decimal = 10'(1 << $urandom_range(0, 9));
                default: decimal = 10'($urandom_range(0, 1023));
            endcase
            enable = ($urandom_range(0, 4) == 0);
            len    = int'($urandom_range(1, 12));
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            for (int k = 0; k < len; k++) begin
                step();
                chk("rand_bcd_range", int'(bcd <= 4'd9), 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
